add8_shared_sched: RTL and testbench

ADD8_SHARED_SCHED -- requirements
Module: add8_shared_sched

---
 rtl/add8_shared_sched.sv | 153 +++++++++++++++
 tb/tb_add8_shared_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/add8_shared_sched.sv
// Two-requester arithmetic scheduler: a round-robin arbiter feeds one shared
// WIDTH-bit adder, sequenced through IDLE/PASS1/PASS2/HOLD with a held result.
module add8_shared_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_z,
  input  logic [WIDTH-1:0] req0_x,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_z,
  input  logic [WIDTH-1:0] req1_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             out_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_TWO  = 2'b10,
    OP_ADDC = 2'b11
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_acc;
  logic             r_id;
  logic             r_last_grant;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [1:0]       w_in_op;
  logic [WIDTH-1:0] w_in_z;
  logic [WIDTH-1:0] w_in_x;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;

  // Ties go to the requester that did not win last; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid)
      w_grant = ~r_last_grant;
    else if (req1_valid)
      w_grant = 1'b1;
  end

  always_comb begin
    w_idle     = (r_state == IDLE) && !ASYNCRESET;
    req0_ready = w_idle && req0_valid && !w_grant;
    req1_ready = w_idle && req1_valid &&  w_grant;
    w_accept   = req0_ready || req1_ready;
    w_in_op    = w_grant ? req1_op : req0_op;
    w_in_z     = w_grant ? req1_z  : req0_z;
    w_in_x     = w_grant ? req1_x  : req0_x;
  end

  // Operand steering for the single shared adder; PASS2 subtracts z from pass 1.
  always_comb begin
    w_add_a = r_z;
    w_add_b = r_x;
    w_cin   = 1'b0;
    if (r_state == PASS2) begin
      w_add_a = r_acc;
      w_add_b = ~r_z;
      w_cin   = 1'b1;
    end else begin
      case (r_op)
        OP_SUB: begin
          w_add_b = ~r_x;
          w_cin   = 1'b1;
        end
        OP_ADDC: w_cin = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_sum = w_add_a + w_add_b + WIDTH'(w_cin);
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_state      <= IDLE;
      r_op         <= OP_ADD;
      r_z          <= '0;
      r_x          <= '0;
      r_acc        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_id       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op         <= op_t'(w_in_op);
            r_z          <= w_in_z;
            r_x          <= w_in_x;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= PASS1;
          end
        end
        PASS1: begin
          if (r_op == OP_TWO) begin
            r_acc   <= w_sum;
            r_state <= PASS2;
          end else begin
            out_a     <= w_sum;
            out_id    <= r_id;
            out_valid <= 1'b1;
            r_state   <= HOLD;
          end
        end
        PASS2: begin
          out_a     <= w_sum;
          out_id    <= r_id;
          out_valid <= 1'b1;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add8_shared_sched.sv
// Scoreboard bench for add8_shared_sched: accepts push expected results,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_add8_shared_sched;

  logic       CLK = 1'b0;
  logic       ASYNCRESET = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
  logic [7:0] req0_z = '0, req0_x = '0, req1_z = '0, req1_x = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_a;
  logic       out_id;

  add8_shared_sched #(.WIDTH(8)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_z(req0_z), .req0_x(req0_x),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_z(req1_z), .req1_x(req1_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_id(out_id)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [1:0] op; logic [7:0] z; logic [7:0] x; logic [7:0] e; } vec_t;
  typedef struct { logic id; logic [7:0] a; int lat; int acc; } exp_t;

  vec_t q0[$];
  vec_t q1[$];
  exp_t sb[$];
  logic exp_grant[$];
  logic [7:0] r0_exp = '0, r1_exp = '0;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_acc0 = 0, n_acc1 = 0, seen0 = 0, seen1 = 0;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put(input logic which, input logic [1:0] op, input logic [7:0] z,
                     input logic [7:0] x, input logic [7:0] e);
    vec_t v;
    v.op = op; v.z = z; v.x = x; v.e = e;
    if (which) q1.push_back(v);
    else       q0.push_back(v);
  endtask

  task automatic note_accept(input logic id, input logic [7:0] e, input logic [1:0] op);
    exp_t t;
    t.id = id; t.a = e; t.lat = (op == 2'b10) ? 3 : 2; t.acc = cyc;
    sb.push_back(t);
    chk("grant_expected", 32'(exp_grant.size() > 0), 32'(1));
    if (exp_grant.size() > 0) chk("grant_id", 32'(id), 32'(exp_grant.pop_front()));
  endtask

  // Monitor: handshakes push expectations, presented results are compared.
  always @(negedge CLK) begin
    cyc++;
    if (ASYNCRESET) begin
      prev_ov = 1'b0;
    end else begin
      chk("dual_ready", 32'(req0_ready && req1_ready), 32'(0));
      if (req0_valid && req0_ready) begin n_acc0++; note_accept(1'b0, r0_exp, req0_op); end
      if (req1_valid && req1_ready) begin n_acc1++; note_accept(1'b1, r1_exp, req1_op); end
      if (out_valid) begin
        chk("result_expected", 32'(sb.size() > 0), 32'(1));
        if (sb.size() > 0) begin
          if (!prev_ov) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          chk("out_a", 32'(out_a), 32'(sb[0].a));
          chk("out_id", 32'(out_id), 32'(sb[0].id));
          chk("ready_in_hold", 32'({req0_ready, req1_ready}), 32'(0));
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  always @(posedge CLK) begin
    vec_t v;
    #1;
    if (n_acc0 != seen0) begin seen0 = n_acc0; req0_valid = 1'b0; end
    if (!req0_valid && q0.size() > 0) begin
      v = q0.pop_front();
      req0_valid = 1'b1; req0_op = v.op; req0_z = v.z; req0_x = v.x; r0_exp = v.e;
    end
  end

  always @(posedge CLK) begin
    vec_t v;
    #1;
    if (n_acc1 != seen1) begin seen1 = n_acc1; req1_valid = 1'b0; end
    if (!req1_valid && q1.size() > 0) begin
      v = q1.pop_front();
      req1_valid = 1'b1; req1_op = v.op; req1_z = v.z; req1_x = v.x; r1_exp = v.e;
    end
  end

  task automatic wait_idle(input int max);
    int k = 0;
    while (k < max && !(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid
                        && sb.size() == 0 && !out_valid)) begin
      @(negedge CLK); #1;
      k++;
    end
    chk("idle_timeout", 32'(k < max), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a0;
    // Reset values, with the first op already waiting at release.
    put(1'b0, 2'b00, 8'hF0, 8'h20, 8'h10); exp_grant.push_back(1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_a", 32'(out_a), 32'(0));
    chk("rst_out_id", 32'(out_id), 32'(0));
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
    ASYNCRESET = 1'b0;
    @(negedge CLK); #1;
    chk("first_accept", 32'(n_acc0), 32'(1));
    wait_idle(40);

    put(1'b1, 2'b01, 8'h05, 8'h07, 8'hFE); exp_grant.push_back(1'b1);
    put(1'b1, 2'b11, 8'hFF, 8'h00, 8'h00); exp_grant.push_back(1'b1);
    wait_idle(40);

    put(1'b0, 2'b10, 8'h9C, 8'h77, 8'h77);
    put(1'b0, 2'b00, 8'hFF, 8'h01, 8'h00);
    put(1'b1, 2'b10, 8'h55, 8'hAA, 8'hAA);
    put(1'b1, 2'b01, 8'h00, 8'h01, 8'hFF);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    wait_idle(80);

    // Back-pressure: result must hold while a second requester waits.
    out_ready = 1'b0;
    put(1'b0, 2'b00, 8'h12, 8'h34, 8'h46); exp_grant.push_back(1'b0);
    k = 0;
    while (!out_valid && k < 30) begin @(negedge CLK); #1; k++; end
    chk("hold_reached", 32'(out_valid), 32'(1));
    put(1'b1, 2'b11, 8'h7F, 8'h80, 8'h00); exp_grant.push_back(1'b1);
    repeat (5) begin
      @(negedge CLK); #1;
      chk("hold_a", 32'(out_a), 32'(8'h46));
      chk("hold_id", 32'(out_id), 32'(0));
      chk("hold_no_ready", 32'({req0_ready, req1_ready}), 32'(0));
    end
    @(posedge CLK); #1 out_ready = 1'b1;
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    chk("idle_after_hold", 32'(out_valid), 32'(0));
    chk("accept_after_hold", 32'(req1_ready), 32'(1));
    wait_idle(40);

    put(1'b0, 2'b00, 8'h01, 8'h02, 8'h03);
    put(1'b0, 2'b01, 8'h10, 8'h01, 8'h0F);
    put(1'b1, 2'b00, 8'h20, 8'h22, 8'h42);
    put(1'b1, 2'b11, 8'h00, 8'h00, 8'h01);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    wait_idle(80);

    // Reset in PASS2 discards the in-flight TWO_OPS and restores req0 priority.
    put(1'b0, 2'b10, 8'h33, 8'h44, 8'h44); exp_grant.push_back(1'b0);
    a0 = n_acc0;
    k = 0;
    while (n_acc0 == a0 && k < 20) begin @(negedge CLK); #1; k++; end
    chk("reset_op_accepted", 32'(n_acc0 != a0), 32'(1));
    @(posedge CLK);
    @(posedge CLK);
    #2 ASYNCRESET = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_a", 32'(out_a), 32'(0));
    chk("rst_mid_id", 32'(out_id), 32'(0));
    sb.delete();
    exp_grant.delete();
    @(negedge CLK);
    @(posedge CLK);
    #2 ASYNCRESET = 1'b0;
    repeat (4) begin
      @(negedge CLK); #1;
      chk("no_stale_result", 32'(out_valid), 32'(0));
    end
    put(1'b0, 2'b00, 8'h0A, 8'h05, 8'h0F);
    put(1'b1, 2'b01, 8'h0A, 8'h05, 8'h05);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    wait_idle(40);

    chk("grant_queue_drained", 32'(exp_grant.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
